// File: rtl/proc_mem_responder.sv
// rtl/proc_mem_responder.sv - word-organised imem/dmem responder with clear sweep, backdoor load, error capture and counters
module proc_mem_responder #(
    parameter int NUM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imemreq_val,
    input  logic [31:0] imemreq_addr,
    output logic [31:0] imemresp_data,
    input  logic        dmemreq_val,
    input  logic        dmemreq_type,
    input  logic [31:0] dmemreq_addr,
    input  logic [31:0] dmemreq_wdata,
    output logic [31:0] dmemresp_rdata,
    input  logic        ld_val,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        busy,
    output logic        err,
    output logic [31:0] err_addr,
    output logic [31:0] imem_count,
    output logic [31:0] dmem_rd_count,
    output logic [31:0] dmem_wr_count
);
    localparam int          AW    = $clog2(NUM_WORDS);
    localparam logic [31:0] LIMIT = 32'(4 * NUM_WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WORDS - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   sweep_idx, sweep_idx_next;
    logic [31:0]     mem [NUM_WORDS];

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < LIMIT);
    endfunction

    logic          imem_ok, dmem_ok, ld_ok;
    logic          imem_acc, dmem_rd_acc, dmem_wr_acc, ld_acc;
    logic          imem_bad, dmem_bad;
    logic [AW-1:0] i_idx, d_idx, l_idx;

    assign imem_ok = addr_ok(imemreq_addr);
    assign dmem_ok = addr_ok(dmemreq_addr);
    assign ld_ok   = addr_ok(ld_addr);
    assign i_idx   = imemreq_addr[AW+1:2];
    assign d_idx   = dmemreq_addr[AW+1:2];
    assign l_idx   = ld_addr[AW+1:2];

    assign imem_acc    = imemreq_val && imem_ok && !busy;
    assign dmem_rd_acc = dmemreq_val && !dmemreq_type && dmem_ok && !busy;
    assign dmem_wr_acc = dmemreq_val && dmemreq_type && dmem_ok && !busy;
    assign ld_acc      = ld_val && ld_ok && !busy;
    assign imem_bad    = imemreq_val && !imem_ok && !busy;
    assign dmem_bad    = dmemreq_val && !dmem_ok && !busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= CLEAR;
            sweep_idx <= '0;
        end else begin
            state     <= state_next;
            sweep_idx <= sweep_idx_next;
        end
    end

    always_comb begin
        state_next     = state;
        sweep_idx_next = sweep_idx;
        busy           = 1'b0;
        case (state)
            CLEAR: begin
                busy           = 1'b1;
                sweep_idx_next = sweep_idx + 1'b1;
                if (sweep_idx == LAST_IDX)
                    state_next = READY;
            end
            default: ;
        endcase
    end

    // Load is applied after the dmem write so it wins on a same-word collision.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[sweep_idx] <= '0;
        end else begin
            if (dmem_wr_acc)
                mem[d_idx] <= dmemreq_wdata;
            if (ld_acc)
                mem[l_idx] <= ld_data;
        end
    end

    assign imemresp_data  = imem_acc    ? mem[i_idx] : '0;
    assign dmemresp_rdata = dmem_rd_acc ? mem[d_idx] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err           <= 1'b0;
            err_addr      <= '0;
            imem_count    <= '0;
            dmem_rd_count <= '0;
            dmem_wr_count <= '0;
        end else begin
            if (imem_bad || dmem_bad) begin
                err <= 1'b1;
                if (!err)
                    err_addr <= dmem_bad ? dmemreq_addr : imemreq_addr;
            end
            if (imem_acc)
                imem_count <= imem_count + 32'd1;
            if (dmem_rd_acc)
                dmem_rd_count <= dmem_rd_count + 32'd1;
            if (dmem_wr_acc)
                dmem_wr_count <= dmem_wr_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_proc_mem_responder.sv
// tb/tb_proc_mem_responder.sv - directed self-checking bench for proc_mem_responder
module tb_proc_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        imemreq_val;
    logic [31:0] imemreq_addr;
    logic [31:0] imemresp_data;
    logic        dmemreq_val;
    logic        dmemreq_type;
    logic [31:0] dmemreq_addr;
    logic [31:0] dmemreq_wdata;
    logic [31:0] dmemresp_rdata;
    logic        ld_val;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        busy;
    logic        err;
    logic [31:0] err_addr;
    logic [31:0] imem_count;
    logic [31:0] dmem_rd_count;
    logic [31:0] dmem_wr_count;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    proc_mem_responder #(.NUM_WORDS(16)) dut (
        .clk(clk), .rst(rst),
        .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(imemresp_data),
        .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
        .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dmemresp_rdata),
        .ld_val(ld_val), .ld_addr(ld_addr), .ld_data(ld_data),
        .busy(busy), .err(err), .err_addr(err_addr),
        .imem_count(imem_count), .dmem_rd_count(dmem_rd_count), .dmem_wr_count(dmem_wr_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        imemreq_val = 0; imemreq_addr = 0;
        dmemreq_val = 0; dmemreq_type = 0; dmemreq_addr = 0; dmemreq_wdata = 0;
        ld_val = 0; ld_addr = 0; ld_data = 0;
    endtask

    task automatic wait_sweep(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 0;
        idle();
        repeat (3) step();
        #1;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy got %0b exp 1", busy); end
        checks++; if (err !== 1'b0 || err_addr !== 32'h0) begin fails++; $display("FAIL reset_err got %0b/%h exp 0/0", err, err_addr); end
        checks++; if (imem_count !== 0 || dmem_rd_count !== 0 || dmem_wr_count !== 0) begin
            fails++; $display("FAIL reset_counts got %0d %0d %0d exp 0", imem_count, dmem_rd_count, dmem_wr_count); end
        checks++; if (imemresp_data !== 0 || dmemresp_rdata !== 0) begin
            fails++; $display("FAIL reset_reads got %h %h exp 0", imemresp_data, dmemresp_rdata); end
        rst = 1;
        wait_sweep(n);
        checks++; if (n !== 16) begin fails++; $display("FAIL sweep_len got %0d exp 16", n); end
    endtask

    task automatic test_cleared_reads();
        for (int i = 0; i < 16; i++) begin
            imemreq_val = 1; imemreq_addr = 32'(i * 4);
            #1;
            checks++; if (imemresp_data !== 32'h0) begin
                fails++; $display("FAIL clear_read[%0d] got %h exp 0", i, imemresp_data); end
            step();
        end
        idle();
        #1;
        checks++; if (imem_count !== 32'd16) begin fails++; $display("FAIL imem_count_sweep got %0d exp 16", imem_count); end
    endtask

    task automatic test_load_and_write();
        ld_val = 1; ld_addr = 32'h8; ld_data = 32'hDEADBEEF;
        step();
        idle();
        imemreq_val = 1; imemreq_addr = 32'h8;
        dmemreq_val = 1; dmemreq_type = 1; dmemreq_addr = 32'h8; dmemreq_wdata = 32'h12345678;
        #1;
        checks++; if (imemresp_data !== 32'hDEADBEEF) begin fails++; $display("FAIL load_read got %h exp deadbeef", imemresp_data); end
        checks++; if (dmemresp_rdata !== 32'h0) begin fails++; $display("FAIL write_rdata got %h exp 0", dmemresp_rdata); end
        step();
        idle();
        dmemreq_val = 1; dmemreq_type = 0; dmemreq_addr = 32'h8;
        #1;
        checks++; if (dmemresp_rdata !== 32'h12345678) begin fails++; $display("FAIL write_read got %h exp 12345678", dmemresp_rdata); end
        checks++; if (dmem_wr_count !== 32'd1) begin fails++; $display("FAIL wr_count1 got %0d exp 1", dmem_wr_count); end
        step();
        idle();
        #1;
        checks++; if (dmem_rd_count !== 32'd1 || imem_count !== 32'd17) begin
            fails++; $display("FAIL counts_after_rw got rd %0d im %0d exp 1 17", dmem_rd_count, imem_count); end
    endtask

    task automatic test_collision();
        ld_val = 1; ld_addr = 32'h4; ld_data = 32'hAAAA0000;
        dmemreq_val = 1; dmemreq_type = 1; dmemreq_addr = 32'h4; dmemreq_wdata = 32'hBBBB0000;
        step();
        idle();
        ld_val = 1; ld_addr = 32'h41; ld_data = 32'h11111111;
        imemreq_val = 1; imemreq_addr = 32'h4;
        #1;
        checks++; if (imemresp_data !== 32'hAAAA0000) begin fails++; $display("FAIL collision got %h exp aaaa0000", imemresp_data); end
        checks++; if (dmem_wr_count !== 32'd2) begin fails++; $display("FAIL wr_count2 got %0d exp 2", dmem_wr_count); end
        step();
        idle();
        #1;
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL bad_ld_no_err got %0b exp 0", err); end
        checks++; if (imem_count !== 32'd18) begin fails++; $display("FAIL imem_count18 got %0d exp 18", imem_count); end
    endtask

    task automatic test_errors();
        dmemreq_val = 1; dmemreq_type = 0; dmemreq_addr = 32'h6;
        #1;
        checks++; if (dmemresp_rdata !== 32'h0) begin fails++; $display("FAIL misalign_rdata got %h exp 0", dmemresp_rdata); end
        step();
        idle();
        #1;
        checks++; if (err !== 1'b1 || err_addr !== 32'h6) begin fails++; $display("FAIL err_capture got %0b/%h exp 1/6", err, err_addr); end
        checks++; if (dmem_rd_count !== 32'd1) begin fails++; $display("FAIL err_rd_count got %0d exp 1", dmem_rd_count); end
        imemreq_val = 1; imemreq_addr = 32'h40;
        #1;
        checks++; if (imemresp_data !== 32'h0) begin fails++; $display("FAIL range_read got %h exp 0", imemresp_data); end
        step();
        idle();
        #1;
        checks++; if (err !== 1'b1 || err_addr !== 32'h6) begin fails++; $display("FAIL err_sticky got %0b/%h exp 1/6", err, err_addr); end
        checks++; if (imem_count !== 32'd18 || dmem_rd_count !== 32'd1 || dmem_wr_count !== 32'd2) begin
            fails++; $display("FAIL err_counts got %0d %0d %0d exp 18 1 2", imem_count, dmem_rd_count, dmem_wr_count); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        rst = 0;
        step();
        rst = 1;
        repeat (7) step();
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_sweep_busy got %0b exp 1", busy); end
        rst = 0;
        step();
        rst = 1;
        wait_sweep(n);
        checks++; if (n !== 16) begin fails++; $display("FAIL restart_sweep_len got %0d exp 16", n); end
        checks++; if (err !== 1'b0 || err_addr !== 32'h0 || imem_count !== 0 || dmem_rd_count !== 0 || dmem_wr_count !== 0) begin
            fails++; $display("FAIL restart_state got err %0b/%h counts %0d %0d %0d exp all 0",
                              err, err_addr, imem_count, dmem_rd_count, dmem_wr_count); end
    endtask

    task automatic test_busy_requests();
        int n;
        rst = 0;
        step();
        rst = 1;
        dmemreq_val = 1; dmemreq_type = 1; dmemreq_addr = 32'h0; dmemreq_wdata = 32'h55;
        imemreq_val = 1; imemreq_addr = 32'h3;
        ld_val = 1; ld_addr = 32'h3C; ld_data = 32'h77;
        #1;
        checks++; if (dmemresp_rdata !== 0 || imemresp_data !== 0) begin
            fails++; $display("FAIL busy_reads got %h %h exp 0", dmemresp_rdata, imemresp_data); end
        wait_sweep(n);
        idle();
        checks++; if (n !== 16) begin fails++; $display("FAIL busy_sweep_len got %0d exp 16", n); end
        checks++; if (err !== 1'b0 || dmem_wr_count !== 0 || imem_count !== 0) begin
            fails++; $display("FAIL busy_ignored got err %0b wr %0d im %0d exp 0", err, dmem_wr_count, imem_count); end
        dmemreq_val = 1; dmemreq_type = 0; dmemreq_addr = 32'h0;
        imemreq_val = 1; imemreq_addr = 32'h3C;
        #1;
        checks++; if (dmemresp_rdata !== 32'h0) begin fails++; $display("FAIL busy_write_blocked got %h exp 0", dmemresp_rdata); end
        checks++; if (imemresp_data !== 32'h0) begin fails++; $display("FAIL busy_load_blocked got %h exp 0", imemresp_data); end
        step();
        idle();
        #1;
        checks++; if (dmem_rd_count !== 32'd1 || imem_count !== 32'd1) begin
            fails++; $display("FAIL post_busy_counts got %0d %0d exp 1 1", dmem_rd_count, imem_count); end
    endtask

    initial begin
        test_reset();
        test_cleared_reads();
        test_load_and_write();
        test_collision();
        test_errors();
        test_reset_mid_sweep();
        test_busy_requests();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
